// File: rtl/rv32_mod_load_store_unit.sv
// Load/store unit: runs one req/ack data-bus transaction per lsu_start.
// Builds byte enables and lane-replicated store data, and extends load data.
// Misaligned accesses, illegal widths, bus errors and timeouts end in a fault.
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   lsu_start/wr/req/addr/wdata request from execute (sampled in IDLE only)
//   lsu_busy/done/rdata         status and extended load result
//   lsu_fault/lsu_fault_cause   fault pulse with done; cause 0 misal, 1 width, 2 bus err, 3 timeout
//   bus_req/wr/addr/be/wdata    data-bus request side
//   bus_ack/err/rdata           data-bus response side
module rv32_mod_load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        lsu_start,
    input  logic        lsu_wr,
    input  logic [2:0]  lsu_req,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [31:0] lsu_rdata,
    output logic        lsu_fault,
    output logic [1:0]  lsu_fault_cause,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    req_q, req_d;
    logic [1:0]    off_q, off_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          fault_q, fault_d;
    logic [1:0]    cause_q, cause_d;
    logic          breq_q, breq_d;
    logic          bwr_q, bwr_d;
    logic [31:0]   baddr_q, baddr_d;
    logic [3:0]    bbe_q, bbe_d;
    logic [31:0]   bwdata_q, bwdata_d;

    logic          illegal_c, misal_c;
    logic [3:0]    be_c;
    logic [31:0]   wdata_c, shifted_c, load_c;

    // Request legality, byte enables and store lane replication
    always_comb begin
        illegal_c = (lsu_req == 3'b011) || (lsu_req[2:1] == 2'b11) || (lsu_wr && lsu_req[2]);
        misal_c   = ((lsu_req[1:0] == 2'b01) && lsu_addr[0]) ||
                    ((lsu_req[1:0] == 2'b10) && (lsu_addr[1:0] != 2'b00));
        case (lsu_req[1:0])
            2'b00: begin
                be_c    = 4'b0001 << lsu_addr[1:0];
                wdata_c = {4{lsu_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = 4'b0011 << {lsu_addr[1], 1'b0};
                wdata_c = {2{lsu_wdata[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = lsu_wdata;
            end
        endcase
    end

    // Load data extraction and extension
    always_comb begin
        shifted_c = bus_rdata >> {off_q, 3'b000};
        case (req_q)
            3'b000:  load_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  load_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  load_c = {24'd0, shifted_c[7:0]};
            3'b101:  load_c = {16'd0, shifted_c[15:0]};
            default: load_c = bus_rdata;
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        off_d    = off_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdata_d  = rdata_q;
        fault_d  = 1'b0;
        cause_d  = cause_q;
        breq_d   = breq_q;
        bwr_d    = bwr_q;
        baddr_d  = baddr_q;
        bbe_d    = bbe_q;
        bwdata_d = bwdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_start) begin
                    busy_d = 1'b1;
                    if (illegal_c || misal_c) begin
                        state_d = S_RESP;
                        done_d  = 1'b1;
                        fault_d = 1'b1;
                        cause_d = illegal_c ? 2'd1 : 2'd0;
                        rdata_d = 32'd0;
                    end else begin
                        state_d  = S_BUS;
                        cnt_d    = '0;
                        req_d    = lsu_req;
                        off_d    = lsu_addr[1:0];
                        breq_d   = 1'b1;
                        bwr_d    = lsu_wr;
                        baddr_d  = {lsu_addr[31:2], 2'b00};
                        bbe_d    = be_c;
                        bwdata_d = lsu_wr ? wdata_c : 32'd0;
                    end
                end
            end
            S_BUS: begin
                cnt_d = cnt_q + CW'(1);
                // err beats ack; ack on the final counted cycle still succeeds
                if (bus_err || bus_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
                    state_d  = S_RESP;
                    done_d   = 1'b1;
                    breq_d   = 1'b0;
                    bwr_d    = 1'b0;
                    baddr_d  = 32'd0;
                    bbe_d    = 4'd0;
                    bwdata_d = 32'd0;
                    rdata_d  = 32'd0;
                    if (bus_err) begin
                        fault_d = 1'b1;
                        cause_d = 2'd2;
                    end else if (bus_ack) begin
                        rdata_d = bwr_q ? 32'd0 : load_c;
                    end else begin
                        fault_d = 1'b1;
                        cause_d = 2'd3;
                    end
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            req_q    <= 3'd0;
            off_q    <= 2'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= 32'd0;
            fault_q  <= 1'b0;
            cause_q  <= 2'd0;
            breq_q   <= 1'b0;
            bwr_q    <= 1'b0;
            baddr_q  <= 32'd0;
            bbe_q    <= 4'd0;
            bwdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            off_q    <= off_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            breq_q   <= breq_d;
            bwr_q    <= bwr_d;
            baddr_q  <= baddr_d;
            bbe_q    <= bbe_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign lsu_busy        = busy_q;
    assign lsu_done        = done_q;
    assign lsu_rdata       = rdata_q;
    assign lsu_fault       = fault_q;
    assign lsu_fault_cause = cause_q;
    assign bus_req         = breq_q;
    assign bus_wr          = bwr_q;
    assign bus_addr        = baddr_q;
    assign bus_be          = bbe_q;
    assign bus_wdata       = bwdata_q;

endmodule

// File: tb/tb_rv32_mod_load_store_unit.sv
// Bench for rv32_mod_load_store_unit (TIMEOUT=8): directed cases then random ops,
// each cycle compared against a byte-level reference model of the access.
module tb_rv32_mod_load_store_unit;
    localparam int unsigned TMO = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lsu_start, lsu_wr;
    logic [2:0]  lsu_req;
    logic [31:0] lsu_addr, lsu_wdata;
    logic        lsu_busy, lsu_done, lsu_fault;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_fault_cause;
    logic        bus_req, bus_wr, bus_ack, bus_err;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    int n_cmp = 0;
    int n_err = 0;

    rv32_mod_load_store_unit #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .lsu_start(lsu_start), .lsu_wr(lsu_wr), .lsu_req(lsu_req),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
        .lsu_fault(lsu_fault), .lsu_fault_cause(lsu_fault_cause),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: access described as a run of n bytes starting at a byte offset
    function automatic int unsigned nbytes(input logic [2:0] req);
        return 1 << req[1:0];
    endfunction

    function automatic bit ref_fault(input logic wr, input logic [2:0] req,
                                     input logic [31:0] addr, output logic [1:0] cause);
        bit illegal;
        illegal = (req == 3) || (req >= 6) || (wr && req >= 4);
        if (illegal) begin cause = 2'd1; return 1; end
        if ((addr % nbytes(req)) != 0) begin cause = 2'd0; return 1; end
        cause = 2'd0;
        return 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] req, input logic [31:0] addr);
        int unsigned m;
        m = ((1 << nbytes(req)) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] req, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(req)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] req, input logic [31:0] addr,
                                             input logic [31:0] rd);
        longint v;
        int unsigned n;
        n = nbytes(req);
        v = longint'((rd >> (8 * (addr % 4)))) & ((64'd1 << (8 * n)) - 1);
        if (req[2] == 1'b0 && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    // One operation: delay = cycles after bus_req rises before ack (>=TMO means never)
    task automatic run_op(input logic wr, input logic [2:0] req, input logic [31:0] addr,
                          input logic [31:0] wd, input int delay, input logic err,
                          input logic [31:0] rd);
        logic [1:0]  cause;
        bit          flt;
        bit          responded;
        logic [31:0] exp_rd;
        flt = ref_fault(wr, req, addr, cause);
        chk("idle_busy", 32'(lsu_busy), 32'd0);
        lsu_start = 1'b1; lsu_wr = wr; lsu_req = req; lsu_addr = addr; lsu_wdata = wd;
        @(negedge clk);
        lsu_start = 1'b0;
        responded = 0;
        exp_rd = 32'd0;
        if (!flt) begin
            for (int k = 0; k < int'(TMO); k++) begin
                chk("bus_req", 32'(bus_req), 32'd1);
                chk("done_early", 32'(lsu_done), 32'd0);
                chk("busy_bus", 32'(lsu_busy), 32'd1);
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be), 32'(ref_be(req, addr)));
                chk("bus_wr", 32'(bus_wr), 32'(wr));
                chk("bus_wdata", bus_wdata, wr ? ref_wdata(req, wd) : 32'd0);
                if (k == delay) begin
                    bus_ack = 1'b1; bus_err = err; bus_rdata = rd;
                    responded = 1;
                end
                @(negedge clk);
                bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
                if (responded) break;
            end
            if (!responded)    begin flt = 1; cause = 2'd3; end
            else if (err)      begin flt = 1; cause = 2'd2; end
            else if (!wr)      exp_rd = ref_load(req, addr, rd);
        end
        chk("done", 32'(lsu_done), 32'd1);
        chk("busy_resp", 32'(lsu_busy), 32'd1);
        chk("req_after", 32'(bus_req), 32'd0);
        chk("fault", 32'(lsu_fault), 32'(flt));
        if (flt) chk("cause", 32'(lsu_fault_cause), 32'(cause));
        chk("rdata", lsu_rdata, exp_rd);
        @(negedge clk);
        chk("done_pulse", 32'(lsu_done), 32'd0);
        chk("busy_end", 32'(lsu_busy), 32'd0);
        chk("rdata_hold", lsu_rdata, exp_rd);
    endtask

    initial begin
        logic [2:0] rq;
        rstn = 1'b0; lsu_start = 1'b0; lsu_wr = 1'b0; lsu_req = 3'd0;
        lsu_addr = 32'd0; lsu_wdata = 32'd0;
        bus_ack = 1'b0; bus_err = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(lsu_busy), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_cause", 32'(lsu_fault_cause), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(1'b0, 3'b010, 32'h100, 32'd0, 3, 1'b0, 32'hDEADBEEF);
        run_op(1'b0, 3'b000, 32'h103, 32'd0, 0, 1'b0, 32'h80123456);
        chk("lb_val", lsu_rdata, 32'hFFFFFF80);
        run_op(1'b0, 3'b100, 32'h103, 32'd0, 1, 1'b0, 32'h80123456);
        chk("lbu_val", lsu_rdata, 32'h00000080);
        run_op(1'b1, 3'b001, 32'h102, 32'h1234ABCD, 2, 1'b0, 32'h0);
        run_op(1'b0, 3'b001, 32'h101, 32'd0, 0, 1'b0, 32'h0);
        run_op(1'b0, 3'b011, 32'h100, 32'd0, 0, 1'b0, 32'h0);
        run_op(1'b1, 3'b100, 32'h100, 32'h55, 0, 1'b0, 32'h0);
        run_op(1'b0, 3'b010, 32'h104, 32'd0, 99, 1'b0, 32'h0);
        run_op(1'b0, 3'b010, 32'h108, 32'd0, int'(TMO) - 1, 1'b0, 32'hCAFEF00D);
        run_op(1'b0, 3'b010, 32'h10C, 32'd0, 2, 1'b1, 32'h12345678);

        // Reset pulse in the middle of a bus cycle abandons the op
        lsu_start = 1'b1; lsu_wr = 1'b0; lsu_req = 3'b010; lsu_addr = 32'h300;
        @(negedge clk);
        lsu_start = 1'b0;
        chk("pre_rst_req", 32'(bus_req), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_busy", 32'(lsu_busy), 32'd0);
        chk("mid_rst_addr", bus_addr, 32'd0);
        chk("mid_rst_done", 32'(lsu_done), 32'd0);
        @(negedge clk);
        chk("post_rst_done", 32'(lsu_done), 32'd0);
        run_op(1'b0, 3'b010, 32'h200, 32'd0, 0, 1'b0, 32'h0BADCAFE);

        // Random operations
        for (int i = 0; i < 60; i++) begin
            rq = 3'($urandom_range(0, 7));
            run_op(1'($urandom), rq, $urandom, $urandom, int'($urandom_range(0, 9)),
                   ($urandom_range(0, 5) == 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
